// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline controller: FSM states, the per-latch control bundle
// and a helper that builds the "everything advances" control word.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } pipe_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic exmem_flush;
        logic memwb_en;
        logic memwb_flush;
    } pipe_ctrl_t;

    // Whole pipeline frozen: nothing moves, nothing is bubbled.
    localparam pipe_ctrl_t CTRL_FROZEN = '0;

    // Every latch and the PC advance, no bubbles inserted.
    function automatic pipe_ctrl_t ctrl_advance();
        pipe_ctrl_t c;
        c          = '0;
        c.pc_en    = 1'b1;
        c.ifid_en  = 1'b1;
        c.idex_en  = 1'b1;
        c.exmem_en = 1'b1;
        c.memwb_en = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline controller (pc) and the datapath (dp).
// The datapath drives hazard/memory status; the controller drives latch controls.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             hz_flush;
    logic             hz_stall;
    logic             ihit;
    logic             dmemREN;
    logic             dmemWEN;
    logic             dhit;
    logic             mem_halt;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             exmem_flush;
    logic             memwb_en;
    logic             memwb_flush;
    logic             halt_out;
    logic [CNT_W-1:0] stall_cnt;

    modport pc (
        input  hz_flush, hz_stall, ihit, dmemREN, dmemWEN, dhit, mem_halt,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_en, memwb_flush, halt_out, stall_cnt
    );

    modport dp (
        output hz_flush, hz_stall, ihit, dmemREN, dmemWEN, dhit, mem_halt,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_en, memwb_flush, halt_out, stall_cnt
    );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping so long runs
// never report a misleadingly small stall figure.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next value: step by one unless already pinned at the maximum.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register, cleared by the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller for the 5-stage MIPS core: merges hazard requests with
// memory waits, parks a flush that arrives while frozen on a data access,
// sequences the halt drain and counts PC-stall cycles.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       nRST,
    pipeline_ctrl_if.pc bus
);

    localparam int             DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]  DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    pipe_state_t     state_q, state_d;
    logic            pend_flush_q, pend_flush_d;
    logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
    logic            halt_q, halt_d;
    pipe_ctrl_t      ctrl;
    logic            dwait;
    logic            stall_inc;
    logic [CNT_W-1:0] stall_cnt;

    assign dwait = (bus.dmemREN | bus.dmemWEN) & ~bus.dhit;

    // Control arbitration and next-state: a data wait freezes everything, then halt,
    // then (live or parked) flush, then load-use stall, then instruction miss.
    always_comb begin
        ctrl         = CTRL_FROZEN;
        state_d      = state_q;
        pend_flush_d = pend_flush_q;
        drain_cnt_d  = drain_cnt_q;
        halt_d       = halt_q;
        case (state_q)
            RUN, DWAIT: begin
                if (dwait) begin
                    pend_flush_d = pend_flush_q | bus.hz_flush;
                    state_d      = DWAIT;
                end else begin
                    ctrl    = ctrl_advance();
                    state_d = RUN;
                    if (bus.mem_halt) begin
                        ctrl.pc_en      = 1'b0;
                        ctrl.ifid_flush = 1'b1;
                        pend_flush_d    = 1'b0;
                        drain_cnt_d     = '0;
                        state_d         = DRAIN;
                    end else if (bus.hz_flush | pend_flush_q) begin
                        ctrl.ifid_flush = 1'b1;
                        ctrl.idex_flush = 1'b1;
                        pend_flush_d    = 1'b0;
                    end else if (bus.hz_stall) begin
                        ctrl.pc_en      = 1'b0;
                        ctrl.ifid_en    = 1'b0;
                        ctrl.idex_flush = 1'b1;
                    end else if (!bus.ihit) begin
                        ctrl.pc_en      = 1'b0;
                        ctrl.ifid_flush = 1'b1;
                    end
                end
            end
            DRAIN: begin
                ctrl.memwb_en = 1'b1;
                drain_cnt_d   = drain_cnt_q + DW'(1);
                if (drain_cnt_q == DRAIN_LAST) begin
                    halt_d  = 1'b1;
                    state_d = HALTED;
                end
            end
            HALTED: begin
                halt_d = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State, parked flush, drain counter and sticky halt registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= RUN;
            pend_flush_q <= 1'b0;
            drain_cnt_q  <= '0;
            halt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_flush_q <= pend_flush_d;
            drain_cnt_q  <= drain_cnt_d;
            halt_q       <= halt_d;
        end
    end

    assign stall_inc = ~ctrl.pc_en & ((state_q == RUN) | (state_q == DWAIT));

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .inc_i   (stall_inc),
        .count_o (stall_cnt)
    );

    assign bus.pc_en       = ctrl.pc_en;
    assign bus.ifid_en     = ctrl.ifid_en;
    assign bus.ifid_flush  = ctrl.ifid_flush;
    assign bus.idex_en     = ctrl.idex_en;
    assign bus.idex_flush  = ctrl.idex_flush;
    assign bus.exmem_en    = ctrl.exmem_en;
    assign bus.exmem_flush = ctrl.exmem_flush;
    assign bus.memwb_en    = ctrl.memwb_en;
    assign bus.memwb_flush = ctrl.memwb_flush;
    assign bus.halt_out    = halt_q;
    assign bus.stall_cnt   = stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: a table of directed cycles, hand-written reset
// sequences, then randomized traffic against a behavioural model.
module tb_pipeline_ctrl;

    localparam int CNT_W        = 4;
    localparam int DRAIN_CYCLES = 1;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    // Control word order: {pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en, memwb_fl}
    localparam logic [8:0] C_ADV   = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] C_FLUSH = 9'b1_1_1_1_1_1_0_1_0;
    localparam logic [8:0] C_STALL = 9'b0_0_0_1_1_1_0_1_0;
    localparam logic [8:0] C_IMISS = 9'b0_1_1_1_0_1_0_1_0;
    localparam logic [8:0] C_HALT  = 9'b0_1_1_1_0_1_0_1_0;
    localparam logic [8:0] C_DRAIN = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] C_FROZE = 9'b0_0_0_0_0_0_0_0_0;

    localparam int M_RUN = 0, M_WAIT = 1, M_DRAIN = 2, M_HALTED = 3;

    typedef struct packed {
        logic fl;
        logic st;
        logic ih;
        logic ren;
        logic wen;
        logic dh;
        logic halt;
    } stim_t;

    typedef struct packed {
        stim_t            s;
        logic [8:0]       ctrl;
        logic             haltOut;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    logic CLK = 1'b0;
    logic nRST;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) ifc ();

    pipeline_ctrl #(
        .CNT_W        (CNT_W),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (ifc)
    );

    always #5 CLK = ~CLK;

    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];

    int   mMode;
    bit   mPend;
    int   mDrain;
    bit   mHalt;
    int   mCnt;

    function automatic logic [8:0] actualCtrl();
        return {ifc.pc_en, ifc.ifid_en, ifc.ifid_flush, ifc.idex_en, ifc.idex_flush,
                ifc.exmem_en, ifc.exmem_flush, ifc.memwb_en, ifc.memwb_flush};
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        ifc.hz_flush = s.fl;
        ifc.hz_stall = s.st;
        ifc.ihit     = s.ih;
        ifc.dmemREN  = s.ren;
        ifc.dmemWEN  = s.wen;
        ifc.dhit     = s.dh;
        ifc.mem_halt = s.halt;
    endtask

    task automatic checkOutput(input string tag, input logic [8:0] ctrl, input logic haltOut,
                               input int cnt);
        compare({tag, " ctrl"}, 32'(actualCtrl()), 32'(ctrl));
        compare({tag, " halt_out"}, 32'(ifc.halt_out), 32'(haltOut));
        compare({tag, " stall_cnt"}, 32'(ifc.stall_cnt), 32'(cnt));
    endtask

    task automatic addVec(input logic [6:0] s, input logic [8:0] c, input logic h, input int cnt);
        vec_t v;
        v.s       = stim_t'(s);
        v.ctrl    = c;
        v.haltOut = h;
        v.cnt     = CNT_W'(cnt);
        vecs.push_back(v);
    endtask

    // Behavioural model: what the pipeline should do this cycle given the mode.
    function automatic logic [8:0] modelExpect(input stim_t s);
        logic busy;
        busy = (s.ren | s.wen) & ~s.dh;
        if (mMode == M_HALTED) return C_FROZE;
        if (mMode == M_DRAIN)  return C_DRAIN;
        if (busy)              return C_FROZE;
        if (s.halt)            return C_HALT;
        if (s.fl || mPend)     return C_FLUSH;
        if (s.st)              return C_STALL;
        if (!s.ih)             return C_IMISS;
        return C_ADV;
    endfunction

    task automatic modelAdvance(input stim_t s, input logic [8:0] ctrlNow);
        logic busy;
        busy = (s.ren | s.wen) & ~s.dh;
        if (mMode == M_RUN || mMode == M_WAIT) begin
            if (!ctrlNow[8] && mCnt < CNT_MAX) mCnt++;
            if (busy) begin
                mPend = mPend | s.fl;
                mMode = M_WAIT;
            end else if (s.halt) begin
                mPend  = 0;
                mDrain = 0;
                mMode  = M_DRAIN;
            end else begin
                mPend = 0;
                mMode = M_RUN;
            end
        end else if (mMode == M_DRAIN) begin
            if (mDrain == DRAIN_CYCLES - 1) begin
                mHalt = 1;
                mMode = M_HALTED;
            end
            mDrain++;
        end
    endtask

    task automatic modelReset();
        mMode  = M_RUN;
        mPend  = 0;
        mDrain = 0;
        mHalt  = 0;
        mCnt   = 0;
    endtask

    // Pulse reset from posedge+1, check asynchronous clearing, release at posedge+1.
    task automatic pulseReset(input string tag);
        applyStimulus(stim_t'(7'b0010000));
        nRST = 1'b0;
        #2;
        checkOutput({tag, " async"}, C_ADV, 1'b0, 0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        modelReset();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        logic [8:0] e;
        logic lastRen, lastWen;
        int haltedFor;

        // Directed table, applied back to back from reset.
        addVec(7'b0010000, C_ADV,   0, 0);
        addVec(7'b0110000, C_STALL, 0, 0);
        addVec(7'b0010000, C_ADV,   0, 1);
        addVec(7'b0011000, C_FROZE, 0, 1);
        addVec(7'b1011000, C_FROZE, 0, 2);
        addVec(7'b0011000, C_FROZE, 0, 3);
        addVec(7'b0011010, C_FLUSH, 0, 4);
        addVec(7'b0010000, C_ADV,   0, 4);
        addVec(7'b1110000, C_FLUSH, 0, 4);
        addVec(7'b0000000, C_IMISS, 0, 4);
        addVec(7'b0000000, C_IMISS, 0, 5);
        addVec(7'b0010000, C_ADV,   0, 6);
        addVec(7'b0011000, C_FROZE, 0, 6);
        addVec(7'b1010110, C_FLUSH, 0, 7);
        addVec(7'b0010000, C_ADV,   0, 7);
        for (int k = 0; k < 11; k++) begin
            addVec(7'b0000000, C_IMISS, 0, (7 + k > CNT_MAX) ? CNT_MAX : 7 + k);
        end
        addVec(7'b0010000, C_ADV,   0, CNT_MAX);
        addVec(7'b0010001, C_HALT,  0, CNT_MAX);
        addVec(7'b0010000, C_DRAIN, 0, CNT_MAX);
        addVec(7'b0010000, C_FROZE, 1, CNT_MAX);
        addVec(7'b1100000, C_FROZE, 1, CNT_MAX);
        addVec(7'b0011000, C_FROZE, 1, CNT_MAX);

        // Reset state with idle inputs.
        applyStimulus(stim_t'(7'b0010000));
        nRST = 1'b0;
        #3;
        checkOutput("reset", C_ADV, 1'b0, 0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].s);
            @(negedge CLK);
            checkOutput($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].haltOut, int'(vecs[i].cnt));
            @(posedge CLK);
            #1;
        end

        // Leaving HALTED only through reset; halt_out must drop without a clock edge.
        pulseReset("halted reset");

        // Reset while waiting on data with a parked flush: the flush must be forgotten.
        applyStimulus(stim_t'(7'b0011000));
        @(negedge CLK);
        checkOutput("dwait1", C_FROZE, 1'b0, 0);
        @(posedge CLK);
        #1;
        applyStimulus(stim_t'(7'b1011000));
        @(negedge CLK);
        checkOutput("dwait2", C_FROZE, 1'b0, 1);
        @(posedge CLK);
        #1;
        pulseReset("dwait reset");
        applyStimulus(stim_t'(7'b0010000));
        @(negedge CLK);
        checkOutput("post reset", C_ADV, 1'b0, 0);
        @(posedge CLK);
        #1;
        applyStimulus(stim_t'(7'b0011010));
        @(negedge CLK);
        checkOutput("post reset dhit", C_ADV, 1'b0, 0);
        @(posedge CLK);
        #1;

        // Randomized traffic against the model.
        modelReset();
        pulseReset("random start");
        lastRen   = 1'b0;
        lastWen   = 1'b0;
        haltedFor = 0;
        for (int i = 0; i < 800; i++) begin
            if ((mMode == M_HALTED && haltedFor >= 3) || $urandom_range(0, 149) == 0) begin
                pulseReset($sformatf("rnd%0d reset", i));
                haltedFor = 0;
            end
            s.fl = ($urandom_range(0, 4) == 0);
            s.st = ($urandom_range(0, 3) == 0);
            s.ih = ($urandom_range(0, 3) != 0);
            if (mMode == M_WAIT) begin
                s.ren = lastRen;
                s.wen = lastWen;
            end else begin
                int r;
                r     = $urandom_range(0, 5);
                s.ren = (r == 0);
                s.wen = (r == 1);
            end
            s.dh   = ($urandom_range(0, 2) == 0);
            s.halt = !s.ren && !s.wen && (mMode != M_WAIT) && ($urandom_range(0, 39) == 0);
            lastRen = s.ren;
            lastWen = s.wen;

            applyStimulus(s);
            @(negedge CLK);
            e = modelExpect(s);
            checkOutput($sformatf("rnd%0d", i), e, mHalt, mCnt);
            @(posedge CLK);
            #1;
            modelAdvance(s, e);
            if (mMode == M_HALTED) haltedFor++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Consumes the hazard requests for the 5-stage MIPS pipeline (branch/jump flush, load-use stall) together with memory handshakes (ihit, dhit) and halt.
- Produces the final per-latch enable/flush controls plus the PC enable.
- Arbitrates priority between hazard and memory-wait conditions, and holds any flush that arrives during a memory freeze until that freeze releases.
- Sequences halt drain and counts stall cycles for performance reporting.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter
- DRAIN_CYCLES, 1, cycles MEM/WB keeps advancing after halt reaches MEM before halt_out asserts

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous reset, active low
- hz_flush  input  1  hazard unit request: flush IF/ID and ID/EX (taken branch, jump, jr)
- hz_stall  input  1  hazard unit request: load-use stall (freeze IF/ID and PC, flush ID/EX)
- ihit  input  1  instruction fetch complete this cycle
- dmemREN  input  1  MEM stage is performing a load
- dmemWEN  input  1  MEM stage is performing a store
- dhit  input  1  data access complete this cycle
- mem_halt  input  1  halt instruction is in the MEM stage
- pc_en  output  1  PC update enable
- ifid_en, idex_en, exmem_en, memwb_en  output  1 each  latch enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  output  1 each  synchronous bubble insert; applies only when the same latch's enable is 1
- halt_out  output  1  registered, sticky halt to system
- stall_cnt  output  CNT_W  saturating count of cycles with pc_en=0 while in RUN or DWAIT

Behaviour:
- Reset (async, nRST=0):
  - state=RUN, pend_flush=0, drain_cnt=0, halt_out=0, stall_cnt=0.
  - Combinational outputs take their RUN values for the current inputs.
- States: RUN, DWAIT, DRAIN, HALTED. Enables and flushes are combinational from state, pend_flush and inputs; halt_out and stall_cnt are registered.
- dwait = (dmemREN|dmemWEN) & ~dhit.
- RUN, priority high to low:
  1. dwait: all enables=0, pc_en=0, all flushes=0. If hz_flush=1, set pend_flush. Next state DWAIT.
  2. hz_flush|pend_flush: all enables=1; ifid_flush=1, idex_flush=1; pc_en=1. Clear pend_flush.
  3. hz_stall: pc_en=0, ifid_en=0; idex_en=1 with idex_flush=1; exmem_en=memwb_en=1.
  4. ~ihit: pc_en=0; ifid_en=1 with ifid_flush=1; downstream enables=1.
  5. Otherwise all enables=1, no flushes, pc_en=1.
- mem_halt in RUN with ~dwait: this cycle behaves as item 5 with pc_en=0 and ifid_flush=1. Next state DRAIN, drain_cnt=0.
- DWAIT:
  - Behaves as RUN item 1 while dwait=1; hz_flush still ORs into pend_flush.
  - When dhit=1, the same cycle acts as RUN (items 2-5 apply, pend_flush honoured). Next state RUN.
- DRAIN:
  - pc_en=0 and ifid/idex/exmem enables=0; memwb_en=1.
  - drain_cnt increments each cycle. When drain_cnt==DRAIN_CYCLES-1: halt_out<=1, next state HALTED.
- HALTED: all enables=0, pc_en=0; halt_out stays 1 until reset.
- stall_cnt: increments when pc_en=0 in RUN/DWAIT; saturates at all-ones and never wraps.
- Simultaneous hz_flush & hz_stall: flush wins, and the stall is not counted separately.
- hz_flush arriving in the same cycle as dhit in DWAIT: applied immediately, not deferred.
- Reset during DWAIT/DRAIN: pend_flush is discarded, and halt_out is cleared asynchronously.

Decomposition:
- cpu_types_pkg gets the pipe_state_t enum {RUN, DWAIT, DRAIN, HALTED} and a pipe_ctrl_t struct packing the four en/flush pairs plus pc_en.
- pipeline_ctrl_if.vh interface with modports pc (block) and dp (datapath), matching existing interface style.
- One natural sub-module, sat_counter (parameterised width, inc, saturate), used for stall_cnt.

Test Plan:
- Reset mid-DWAIT with pend_flush=1 → after nRST release: RUN, pc_en=1, no flush outputs, stall_cnt=0, halt_out=0.
- Load-use: hz_stall=1 one cycle, ihit=1 → pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1; stall_cnt goes 0→1.
- dmemREN=1 with dhit=0 for 3 cycles, hz_flush=1 on the second cycle, then dhit=1 → all enables 0 for 3 cycles; on the dhit cycle ifid_flush=idex_flush=1 and pc_en=1; the next cycle has no flushes.
- hz_flush=1 and hz_stall=1 together → ifid_flush=idex_flush=1, pc_en=1, ifid_en=1.
- ihit=0 for 2 cycles → pc_en=0, ifid_flush=1, idex/exmem/memwb enables=1; stall_cnt +2.
- mem_halt=1, DRAIN_CYCLES=1 → next cycle memwb_en=1 and others 0; halt_out=1 the following cycle, then HALTED with all enables 0 indefinitely.
- Force stall_cnt to all-ones minus one (CNT_W=4, i.e. 14), then 3 stall cycles → stall_cnt ends at 15 with no wrap.
